// File: rtl/led_matrix_driver.sv
// Scans a 256-pixel frame snapshot onto a 16x16 single-colour panel (1/8 scan, two data lines).
// Panel outputs are decoded from the scan state; only addr is held in its own register.
module led_matrix_driver #(
    parameter int CLK_DIV = 4,
    parameter int ON_TIME = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] matrix,
    output logic         sclk,
    output logic         r0,
    output logic         r1,
    output logic         lat,
    output logic         oe_n,
    output logic [2:0]   addr,
    output logic         frame_done
);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_TIME - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t         r_state, w_state_next;
    logic [255:0]   r_snap;
    logic [2:0]     r_row, w_row_next;
    logic [3:0]     r_bit, w_bit_next;
    logic [7:0]     r_div, w_div_next;
    logic           r_phase, w_phase_next;
    logic [15:0]    r_on, w_on_next;
    logic [2:0]     r_addr, w_addr_next;
    logic           w_snap_load;
    logic           w_shifting;
    logic [15:0]    w_upper [8];
    logic [15:0]    w_lower [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rows
            assign w_upper[gi] = r_snap[gi*16 +: 16];
            assign w_lower[gi] = r_snap[(gi+8)*16 +: 16];
        end
    endgenerate

    // Bit k carries column 15-k, so the column index is simply ~bit.
    assign r0   = w_shifting & w_upper[r_row][~r_bit];
    assign r1   = w_shifting & w_lower[r_row][~r_bit];
    assign addr = r_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
            r_snap  <= '0;
            r_row   <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_on    <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_bit   <= w_bit_next;
            r_div   <= w_div_next;
            r_phase <= w_phase_next;
            r_on    <= w_on_next;
            r_addr  <= w_addr_next;
            if (w_snap_load) begin
                r_snap <= matrix;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_bit_next   = r_bit;
        w_div_next   = r_div;
        w_phase_next = r_phase;
        w_on_next    = r_on;
        w_addr_next  = r_addr;
        w_snap_load  = 1'b0;
        w_shifting   = 1'b0;
        sclk         = 1'b0;
        lat          = 1'b0;
        oe_n         = 1'b1;
        frame_done   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_snap_load  = 1'b1;
                w_row_next   = '0;
                w_bit_next   = '0;
                w_div_next   = '0;
                w_phase_next = 1'b0;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_shifting = 1'b1;
                sclk       = r_phase;
                if (r_div == DIV_LAST) begin
                    w_div_next = '0;
                    if (r_phase) begin
                        w_phase_next = 1'b0;
                        if (r_bit == 4'd15) begin
                            w_state_next = S_BLANK;
                        end else begin
                            w_bit_next = r_bit + 4'd1;
                        end
                    end else begin
                        w_phase_next = 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_BLANK: begin
                // addr moves only here, so it is settled before the latch and display.
                w_addr_next  = r_row;
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                lat          = 1'b1;
                w_on_next    = '0;
                w_state_next = S_DISPLAY;
            end
            S_DISPLAY: begin
                oe_n = 1'b0;
                if (r_on == ON_LAST) begin
                    if (r_row == 3'd7) begin
                        frame_done   = 1'b1;
                        w_state_next = S_LOAD;
                    end else begin
                        w_row_next   = r_row + 3'd1;
                        w_bit_next   = '0;
                        w_div_next   = '0;
                        w_phase_next = 1'b0;
                        w_state_next = S_SHIFT;
                    end
                end else begin
                    w_on_next = r_on + 16'd1;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end
endmodule
